uart_rx_fsm_core: RTL and testbench

//  UART receiver companion to the UART TX path: 8N1 (optionally 8E1) serial-to-parallel.

---
 rtl/uart_pkg.sv | 28 ++
 rtl/uart_rx_fsm_core_if.sv | 23 ++
 rtl/uart_rx_baud_cnt.sv | 30 +++
 rtl/uart_rx_fsm_core.sv | 138 +++++++++++++
 tb/tb_uart_rx_fsm_core.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding, divisor helper, default payload width.
// The TX and RX FSM cores both import this package.
package uart_pkg;

  localparam int DATA_BITS_DEF = 8;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;
  localparam logic [2:0] LOAD   = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE   = IDLE,
    ST_START  = START,
    ST_DATA   = DATA,
    ST_PARITY = PARITY,
    ST_STOP   = STOP,
    ST_LOAD   = LOAD
  } uart_state_e;

  // Clocks per bit; callers must keep the result at 4 or more.
  function automatic int calc_div(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_rx_fsm_core_if.sv
// Consumer-side bus of the UART receiver: received byte, status flags, ack strobe.
interface uart_rx_fsm_core_if
  import uart_pkg::*;
#(
  parameter int DATA_BITS = DATA_BITS_DEF
);
  logic                 i_rx_ack;
  logic [DATA_BITS-1:0] o_rx_data;
  logic                 o_rx_valid;
  logic                 o_frame_err;
  logic                 o_parity_err;
  logic                 o_overrun;

  modport master (
    input  i_rx_ack,
    output o_rx_data, o_rx_valid, o_frame_err, o_parity_err, o_overrun
  );

  modport slave (
    output i_rx_ack,
    input  o_rx_data, o_rx_valid, o_frame_err, o_parity_err, o_overrun
  );
endinterface

// File: rtl/uart_rx_baud_cnt.sv
// Bit-period counter for the UART receiver: half- and full-period terminal counts,
// wraps on full terminal count, synchronous clear.
module uart_rx_baud_cnt #(
  parameter int DIV = 10
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  output logic o_half_tc,
  output logic o_full_tc
);
  localparam int CNT_W = $clog2(DIV);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(DIV / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (i_clr || (cnt_q == FULL_LAST)) cnt_d = '0;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign o_half_tc = (cnt_q == HALF_LAST);
  assign o_full_tc = (cnt_q == FULL_LAST);
endmodule

// File: rtl/uart_rx_fsm_core.sv
// UART receiver core: 8N1 serial-to-parallel with mid-bit sampling and valid/ack handoff.
// Define UART_RX_PARITY_EN to build the 8E1 variant (even parity, PARITY state).
module uart_rx_fsm_core
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD      = 115_200,
  parameter int DATA_BITS = DATA_BITS_DEF
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_rx,
  uart_rx_fsm_core_if.master rx_bus,
  output logic               o_busy,
  output logic [2:0]         o_state
);
  localparam int DIV   = calc_div(CLK_FREQ, BAUD);
  localparam int BIT_W = $clog2(DATA_BITS);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);

  uart_state_e          state_q;
  logic [1:0]           sync_q;
  logic [BIT_W-1:0]     bit_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [DATA_BITS-1:0] data_q;
  logic                 valid_q;
  logic                 ferr_q;
  logic                 ferr_pend_q;
  logic                 ovr_q;
  logic                 rxs;
  logic                 half_tc;
  logic                 full_tc;
  logic                 baud_clr;
`ifdef UART_RX_PARITY_EN
  logic                 perr_q;
  logic                 perr_pend_q;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) sync_q <= 2'b11;
    else          sync_q <= {sync_q[0], i_rx};
  end
  assign rxs = sync_q[1];

  // Bit-period timing restarts on every state change; inside DATA the counter free-wraps.
  assign baud_clr = (state_q == ST_IDLE) || (state_q == ST_LOAD) ||
                    ((state_q == ST_START) && half_tc);

  uart_rx_baud_cnt #(.DIV(DIV)) u_baud_cnt (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_clr     (baud_clr),
    .o_half_tc (half_tc),
    .o_full_tc (full_tc)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= ST_IDLE;
      bit_q       <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      ferr_q      <= 1'b0;
      ferr_pend_q <= 1'b0;
      ovr_q       <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q      <= 1'b0;
      perr_pend_q <= 1'b0;
`endif
    end else begin
      if (rx_bus.i_rx_ack && valid_q) begin
        valid_q <= 1'b0;
        ovr_q   <= 1'b0;
      end
      case (state_q)
        ST_IDLE: if (!rxs) state_q <= ST_START;
        ST_START: begin
          if (half_tc) begin
            bit_q   <= '0;
            state_q <= rxs ? ST_IDLE : ST_DATA;
          end
        end
        ST_DATA: begin
          if (full_tc) begin
            shift_q <= {rxs, shift_q[DATA_BITS-1:1]};
            bit_q   <= bit_q + BIT_W'(1);
            if (bit_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
              state_q <= ST_PARITY;
`else
              state_q <= ST_STOP;
`endif
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (full_tc) begin
            perr_pend_q <= rxs ^ (^shift_q);
            state_q     <= ST_STOP;
          end
        end
`endif
        ST_STOP: begin
          if (full_tc) begin
            ferr_pend_q <= ~rxs;
            state_q     <= ST_LOAD;
          end
        end
        // Loading overrides a same-cycle ack: the new byte stays valid and overrun records the loss.
        ST_LOAD: begin
          data_q  <= shift_q;
          ferr_q  <= ferr_pend_q;
          valid_q <= 1'b1;
          if (valid_q) ovr_q <= 1'b1;
`ifdef UART_RX_PARITY_EN
          perr_q  <= perr_pend_q;
`endif
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign rx_bus.o_rx_data   = data_q;
  assign rx_bus.o_rx_valid  = valid_q;
  assign rx_bus.o_frame_err = ferr_q;
  assign rx_bus.o_overrun   = ovr_q;
`ifdef UART_RX_PARITY_EN
  assign rx_bus.o_parity_err = perr_q;
`else
  assign rx_bus.o_parity_err = 1'b0;
`endif
  assign o_busy  = (state_q != ST_IDLE);
  assign o_state = state_q;
endmodule

// File: tb/tb_uart_rx_fsm_core.sv
// Self-checking bench for uart_rx_fsm_core: directed frames plus randomized bytes,
// compared against a frame-level reference model of the receiver's visible outputs.
`timescale 1ns/1ps
module tb_uart_rx_fsm_core;
  localparam int CLK_FREQ = 1_000_000;
  localparam int BAUD     = 100_000;
  localparam int DIV      = CLK_FREQ / BAUD;
`ifdef UART_RX_PARITY_EN
  localparam int NBITS = 11;
  localparam bit PAR_EN = 1'b1;
`else
  localparam int NBITS = 10;
  localparam bit PAR_EN = 1'b0;
`endif

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx    = 1'b1;
  logic       busy;
  logic [2:0] state;

  uart_rx_fsm_core_if #(.DATA_BITS(8)) rx_bus ();

  uart_rx_fsm_core #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD      (BAUD),
    .DATA_BITS (8)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_rx    (rx),
    .rx_bus  (rx_bus),
    .o_busy  (busy),
    .o_state (state)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;
  int unsigned rise_cyc = 0;
  logic        vld_d = 1'b0;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    vld_d <= rx_bus.o_rx_valid;
    if (rx_bus.o_rx_valid && !vld_d) rise_cyc <= cyc;
  end

  // Reference model of the consumer-visible state.
  logic [7:0] exp_data  = 8'h00;
  logic       exp_valid = 1'b0;
  logic       exp_ferr  = 1'b0;
  logic       exp_perr  = 1'b0;
  logic       exp_ovr   = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic b);
    rx = b;
    tick(DIV);
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".data"},   32'(rx_bus.o_rx_data),    32'(exp_data));
    chk({tag, ".valid"},  32'(rx_bus.o_rx_valid),   32'(exp_valid));
    chk({tag, ".ferr"},   32'(rx_bus.o_frame_err),  32'(exp_ferr));
    chk({tag, ".perr"},   32'(rx_bus.o_parity_err), 32'(exp_perr));
    chk({tag, ".ovr"},    32'(rx_bus.o_overrun),    32'(exp_ovr));
  endtask

  // One full frame, then a two-bit idle gap; updates the model with what a receiver must report.
  task automatic send_frame(input string tag, input logic [7:0] d, input logic stop_b,
                            input logic par_ok);
    int unsigned start_cyc;
    logic        was_valid;
    was_valid = exp_valid;
    start_cyc = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    if (PAR_EN) drive_bit((^d) ^ ~par_ok);
    drive_bit(stop_b);
    rx = 1'b1;
    exp_ovr   = exp_ovr | exp_valid;
    exp_valid = 1'b1;
    exp_data  = d;
    exp_ferr  = ~stop_b;
    exp_perr  = PAR_EN ? ~par_ok : 1'b0;
    if (!was_valid) begin
      chk({tag, ".lat_lo"}, 32'(rise_cyc - start_cyc >= DIV * (NBITS - 1) + DIV / 2), 32'd1);
      chk({tag, ".lat_hi"}, 32'(rise_cyc - start_cyc <= DIV * NBITS), 32'd1);
    end
    check_outputs(tag);
    tick(2 * DIV);
  endtask

  task automatic ack(input string tag);
    rx_bus.i_rx_ack = 1'b1;
    tick(1);
    rx_bus.i_rx_ack = 1'b0;
    exp_valid = 1'b0;
    exp_ovr   = 1'b0;
    check_outputs(tag);
  endtask

  initial begin
    logic [7:0] rd;
    logic       rs;
    logic       rp;
    rx_bus.i_rx_ack = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(2);
    check_outputs("reset");
    chk("reset.busy",  32'(busy),  32'd0);
    chk("reset.state", 32'(state), 32'd0);

    send_frame("t1_a5", 8'hA5, 1'b1, 1'b1);
    ack("t1_ack");

    rx = 1'b0;
    tick(3);
    rx = 1'b1;
    chk("t2.busy_mid", 32'(busy), 32'd1);
    tick(2 * DIV);
    check_outputs("t2_glitch");
    chk("t2.busy",  32'(busy),  32'd0);
    chk("t2.state", 32'(state), 32'd0);

    send_frame("t3_3c_ferr", 8'h3C, 1'b0, 1'b1);
    ack("t3_ack");

    send_frame("t4_11", 8'h11, 1'b1, 1'b1);
    send_frame("t4_22", 8'h22, 1'b1, 1'b1);
    ack("t4_ack");

`ifdef UART_RX_PARITY_EN
    send_frame("t5_07_bad", 8'h07, 1'b1, 1'b0);
    ack("t5_ack_bad");
    send_frame("t5_07_good", 8'h07, 1'b1, 1'b1);
    ack("t5_ack_good");
`endif

    // Leave a byte pending, then reset in the middle of bit 4 of the next frame.
    send_frame("t6_pre", 8'hC3, 1'b1, 1'b1);
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b0);
    rx = 1'b1;
    tick(DIV / 2);
    chk("t6.busy_pre", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    exp_data = 8'h00; exp_valid = 1'b0; exp_ferr = 1'b0; exp_perr = 1'b0; exp_ovr = 1'b0;
    check_outputs("t6_rst");
    chk("t6.busy",  32'(busy),  32'd0);
    chk("t6.state", 32'(state), 32'd0);
    tick(2);
    rst_n = 1'b1;
    tick(2 * DIV);
    send_frame("t6_5a", 8'h5A, 1'b1, 1'b1);
    ack("t6_ack");

    for (int n = 0; n < 16; n++) begin
      rd = 8'($urandom_range(0, 255));
      rs = ($urandom_range(0, 3) != 0);
      rp = ($urandom_range(0, 3) != 0);
      send_frame($sformatf("rnd%0d", n), rd, rs, rp);
      if ($urandom_range(0, 1) == 1) ack($sformatf("rnd%0d_ack", n));
    end
    ack("final_ack");
    chk("final.busy", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
